qcore_ctrl_pipe: RTL and testbench



---
 rtl/qcore_ctrl_pipe.sv | 113 +++++++++++
 tb/tb_qcore_ctrl_pipe.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/qcore_ctrl_pipe.sv
// qcore_ctrl_pipe: pipeline-control sequencer for the qcore issue path.
// Owns the RD/X1/X2/WR control-word registers, advances them each cycle and
// inserts zero control words (bubbles) on flush, hazard bubbles and halt.
// Also keeps a saturating stall counter and a consecutive-stall watchdog.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   halt_i                freeze every register (counters, watchdog, stages)
//   id_vld_i, id_ctrl_i   ID-stage valid and control word
//   id_ready_o            combinational: ID word accepted this cycle
//   bubble_id_i           hold ID, inject bubble into RD
//   bubble_rd_i           hold ID and RD, inject bubble into X1
//   flush_i               kill RD and the ID instruction
//   rd/x1/x2/wr_ctrl_o    registered stage control words
//   cnt_clr_i             synchronous clear of counters and error flag
//   stall_cnt_o           saturating total stall-cycle count
//   stall_err_o           sticky watchdog error
module qcore_ctrl_pipe #(
    parameter int unsigned CW        = 12,
    parameter int unsigned STALL_MAX = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          halt_i,
    input  logic          id_vld_i,
    input  logic [CW-1:0] id_ctrl_i,
    output logic          id_ready_o,
    input  logic          bubble_id_i,
    input  logic          bubble_rd_i,
    input  logic          flush_i,
    output logic [CW-1:0] rd_ctrl_o,
    output logic [CW-1:0] x1_ctrl_o,
    output logic [CW-1:0] x2_ctrl_o,
    output logic [CW-1:0] wr_ctrl_o,
    input  logic          cnt_clr_i,
    output logic [15:0]   stall_cnt_o,
    output logic          stall_err_o
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(STALL_MAX);

    logic [CW-1:0]    rd_d, x1_d, x2_d, wr_d;
    logic [CNT_W-1:0] wd_q, wd_inc, stall_inc;
    logic             stall_c;

    assign id_ready_o = ~halt_i & ~flush_i & ~bubble_rd_i & ~bubble_id_i;
    assign stall_c    = ~halt_i & (bubble_id_i | bubble_rd_i) & ~flush_i;

    // Both counters saturate; the watchdog stops at its limit so a limit of
    // 65535 cannot wrap back to zero.
    assign stall_inc = (stall_cnt_o == '1) ? stall_cnt_o : stall_cnt_o + CNT_W'(1);
    assign wd_inc    = (wd_q == WD_LIMIT)  ? wd_q        : wd_q + CNT_W'(1);

    // Stage next-state: priority flush > bubble_rd > bubble_id > normal issue.
    always_comb begin
        rd_d = rd_ctrl_o;
        x1_d = x1_ctrl_o;
        x2_d = x2_ctrl_o;
        wr_d = wr_ctrl_o;
        if (!halt_i) begin
            wr_d = x2_ctrl_o;
            x2_d = x1_ctrl_o;
            if (flush_i) begin
                x1_d = '0;
                rd_d = '0;
            end else if (bubble_rd_i) begin
                x1_d = '0;
            end else if (bubble_id_i) begin
                x1_d = rd_ctrl_o;
                rd_d = '0;
            end else begin
                x1_d = rd_ctrl_o;
                rd_d = id_vld_i ? id_ctrl_i : '0;
            end
        end
    end

    // Stage registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ctrl_o <= '0;
            x1_ctrl_o <= '0;
            x2_ctrl_o <= '0;
            wr_ctrl_o <= '0;
        end else begin
            rd_ctrl_o <= rd_d;
            x1_ctrl_o <= x1_d;
            x2_ctrl_o <= x2_d;
            wr_ctrl_o <= wr_d;
        end
    end

    // Stall statistics and watchdog; clear acts even while halted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            wd_q        <= '0;
            stall_err_o <= 1'b0;
        end else if (cnt_clr_i) begin
            stall_cnt_o <= '0;
            wd_q        <= '0;
            stall_err_o <= 1'b0;
        end else if (stall_c) begin
            stall_cnt_o <= stall_inc;
            wd_q        <= wd_inc;
            stall_err_o <= stall_err_o | (wd_inc == WD_LIMIT);
        end else if (!halt_i) begin
            wd_q <= '0;
        end
    end

endmodule

// File: tb/tb_qcore_ctrl_pipe.sv
// Directed bench for qcore_ctrl_pipe: streaming latency, bubbles, flush,
// halt freeze, watchdog, counter clear, saturation and async reset.
module tb_qcore_ctrl_pipe;

    localparam int unsigned CW = 12;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          halt_i;
    logic          id_vld_i;
    logic [CW-1:0] id_ctrl_i;
    logic          id_ready_o;
    logic          bubble_id_i;
    logic          bubble_rd_i;
    logic          flush_i;
    logic [CW-1:0] rd_ctrl_o, x1_ctrl_o, x2_ctrl_o, wr_ctrl_o;
    logic          cnt_clr_i;
    logic [15:0]   stall_cnt_o;
    logic          stall_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    qcore_ctrl_pipe #(.CW(CW), .STALL_MAX(64)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .halt_i      (halt_i),
        .id_vld_i    (id_vld_i),
        .id_ctrl_i   (id_ctrl_i),
        .id_ready_o  (id_ready_o),
        .bubble_id_i (bubble_id_i),
        .bubble_rd_i (bubble_rd_i),
        .flush_i     (flush_i),
        .rd_ctrl_o   (rd_ctrl_o),
        .x1_ctrl_o   (x1_ctrl_o),
        .x2_ctrl_o   (x2_ctrl_o),
        .wr_ctrl_o   (wr_ctrl_o),
        .cnt_clr_i   (cnt_clr_i),
        .stall_cnt_o (stall_cnt_o),
        .stall_err_o (stall_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle 1 time unit past it before checking.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_stages(input string tag, input logic [CW-1:0] rd, input logic [CW-1:0] x1,
                                input logic [CW-1:0] x2, input logic [CW-1:0] wr);
        check_eq({tag, ".rd"}, 32'(rd_ctrl_o), 32'(rd));
        check_eq({tag, ".x1"}, 32'(x1_ctrl_o), 32'(x1));
        check_eq({tag, ".x2"}, 32'(x2_ctrl_o), 32'(x2));
        check_eq({tag, ".wr"}, 32'(wr_ctrl_o), 32'(wr));
    endtask

    initial begin
        rst_i = 1'b1; halt_i = 1'b0; id_vld_i = 1'b0; id_ctrl_i = '0;
        bubble_id_i = 1'b0; bubble_rd_i = 1'b0; flush_i = 1'b0; cnt_clr_i = 1'b0;
        #12;
        check_stages("reset", 12'h0, 12'h0, 12'h0, 12'h0);
        check_eq("reset.stall_cnt", 32'(stall_cnt_o), 32'h0);
        check_eq("reset.stall_err", 32'(stall_err_o), 32'h0);
        check_eq("reset.id_ready", 32'(id_ready_o), 32'h1);
        rst_i = 1'b0;

        // Stream A, B, C: each reaches WR four edges after acceptance.
        id_vld_i = 1'b1; id_ctrl_i = 12'h801; step();
        check_stages("s1", 12'h801, 12'h0, 12'h0, 12'h0);
        id_ctrl_i = 12'h802; step();
        id_ctrl_i = 12'h803; step();
        check_stages("s3", 12'h803, 12'h802, 12'h801, 12'h0);
        id_vld_i = 1'b0; id_ctrl_i = '0; step();
        check_stages("s4", 12'h0, 12'h803, 12'h802, 12'h801);
        step();
        check_eq("s5.wr", 32'(wr_ctrl_o), 32'h802);
        step();
        check_eq("s6.wr", 32'(wr_ctrl_o), 32'h803);
        check_eq("s6.stall_cnt", 32'(stall_cnt_o), 32'h0);

        // One-cycle bubble_rd with RD=0x902, X1=0x901.
        id_vld_i = 1'b1; id_ctrl_i = 12'h901; step();
        id_ctrl_i = 12'h902; step();
        id_ctrl_i = 12'h903; bubble_rd_i = 1'b1;
        #1 check_eq("brd.id_ready", 32'(id_ready_o), 32'h0);
        step();
        check_stages("brd", 12'h902, 12'h0, 12'h901, 12'h0);
        check_eq("brd.stall_cnt", 32'(stall_cnt_o), 32'h1);
        bubble_rd_i = 1'b0; step();
        check_stages("brd_after", 12'h903, 12'h902, 12'h0, 12'h901);

        // Flush together with bubble_id: flush wins, no stall counted.
        id_ctrl_i = 12'h904; flush_i = 1'b1; bubble_id_i = 1'b1;
        #1 check_eq("flush.id_ready", 32'(id_ready_o), 32'h0);
        step();
        check_stages("flush", 12'h0, 12'h0, 12'h902, 12'h0);
        check_eq("flush.stall_cnt", 32'(stall_cnt_o), 32'h1);
        flush_i = 1'b0; bubble_id_i = 1'b0;

        // Halt for 5 cycles while toggling bubble_rd: everything frozen.
        id_ctrl_i = 12'h905; step();
        id_ctrl_i = 12'h906; step();
        check_stages("pre_halt", 12'h906, 12'h905, 12'h0, 12'h0);
        halt_i = 1'b1; id_ctrl_i = 12'h907;
        for (int i = 0; i < 5; i++) begin
            bubble_rd_i = i[0];
            #1 check_eq("halt.id_ready", 32'(id_ready_o), 32'h0);
            step();
            check_stages("halt", 12'h906, 12'h905, 12'h0, 12'h0);
            check_eq("halt.stall_cnt", 32'(stall_cnt_o), 32'h1);
        end
        halt_i = 1'b0; bubble_rd_i = 1'b0; step();
        check_stages("resume", 12'h907, 12'h906, 12'h905, 12'h0);
        id_vld_i = 1'b0; id_ctrl_i = '0;

        // Clear, then 64 consecutive bubble_id stalls trip the watchdog.
        cnt_clr_i = 1'b1; step();
        cnt_clr_i = 1'b0;
        check_eq("clr.stall_cnt", 32'(stall_cnt_o), 32'h0);
        bubble_id_i = 1'b1;
        for (int i = 0; i < 63; i++) step();
        check_eq("wd63.err", 32'(stall_err_o), 32'h0);
        step();
        check_eq("wd64.err", 32'(stall_err_o), 32'h1);
        check_eq("wd64.stall_cnt", 32'(stall_cnt_o), 32'd64);
        bubble_id_i = 1'b0; step();
        check_eq("wd_sticky.err", 32'(stall_err_o), 32'h1);
        // Clear beats a same-cycle stall increment.
        bubble_id_i = 1'b1; cnt_clr_i = 1'b1; step();
        cnt_clr_i = 1'b0; bubble_id_i = 1'b0;
        check_eq("wdclr.err", 32'(stall_err_o), 32'h0);
        check_eq("wdclr.stall_cnt", 32'(stall_cnt_o), 32'h0);

        // Saturation of the stall counter.
        bubble_id_i = 1'b1;
        for (int i = 0; i < 65540; i++) step();
        check_eq("sat.stall_cnt", 32'(stall_cnt_o), 32'hFFFF);
        check_eq("sat.err", 32'(stall_err_o), 32'h1);
        bubble_id_i = 1'b0;

        // Load some words, then reset asynchronously mid-cycle.
        id_vld_i = 1'b1; id_ctrl_i = 12'hA01; step();
        id_ctrl_i = 12'hA02; step();
        check_stages("pre_rst", 12'hA02, 12'hA01, 12'h0, 12'h0);
        #2 rst_i = 1'b1;
        #1;
        check_stages("async_rst", 12'h0, 12'h0, 12'h0, 12'h0);
        check_eq("async_rst.stall_cnt", 32'(stall_cnt_o), 32'h0);
        check_eq("async_rst.err", 32'(stall_err_o), 32'h0);
        #10 rst_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
